// File: rtl/alu_arbiter_if.sv
// Issue/response bundle between NUM_REQ requesters and the shared-ALU arbiter.
// The arbiter takes the slave modport; requesters (or a bench) take master.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [5*NUM_REQ-1:0]  req_opcode;
  logic [5*NUM_REQ-1:0]  req_shamt;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_ne;
  logic                  rsp_lt;
  logic                  rsp_ovf;
  logic                  busy;

  modport master (
    output req_valid, req_opcode, req_shamt, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_opcode, req_shamt, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between NUM_REQ requesters, one transaction in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);
  localparam int DATA_W = 32;

  // Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, anything else runs as ADD.
  function automatic logic [DATA_W-1:0] alu_result(input logic [4:0] op, input logic [4:0] sh,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a << sh;
      5'd5:    r = a >>> sh;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic alu_ovf(input logic [4:0] op,
                                   input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] s;
    logic raw;
    if (op == 5'd1) begin
      s   = a - b;
      raw = (a[DATA_W-1] != b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    end else begin
      s   = a + b;
      raw = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    end
    return raw && !(op inside {[5'd2:5'd5]});
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [IDW-1:0]           gnt_q, gnt_d, base;
  logic                     found, accept;
  logic [4:0]               op_q, sh_q;
  logic signed [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0]        res_q;
  logic                     ne_q, lt_q, ovf_q;
  logic [IDW-1:0]           id_q;
  logic [NUM_REQ-1:0]       ready_d, rsp_valid_d;

  // Winner search starts at the highest-priority index and wraps.
  always_comb begin
    gnt_d = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(base) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt_d = IDW'((int'(base) + k) % NUM_REQ);
      end
    end
  end

  assign accept = (state_q == IDLE) && found;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDW-1:0] ptr_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    ptr_q <= '0;
    else if (accept) ptr_q <= (int'(gnt_d) == NUM_REQ - 1) ? '0 : gnt_d + 1'b1;
  end
  assign base = ptr_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) gnt_q <= gnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d = EXEC;
        ready_d = NUM_REQ'(1) << gnt_d;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_d = NUM_REQ'(1) << id_q;
        if (bus.rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: operands captured at accept; datapath only, no reset needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q <= bus.req_opcode[5*gnt_d +: 5];
      sh_q <= bus.req_shamt[5*gnt_d +: 5];
      a_q  <= bus.req_a[32*gnt_d +: 32];
      b_q  <= bus.req_b[32*gnt_d +: 32];
    end
  end

  // p1: ALU result registered in EXEC; held until the next EXEC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      ne_q  <= 1'b0;
      lt_q  <= 1'b0;
      ovf_q <= 1'b0;
      id_q  <= '0;
    end else if (state_q == EXEC) begin
      res_q <= alu_result(op_q, sh_q, a_q, b_q);
      ne_q  <= (a_q != b_q);
      lt_q  <= (a_q < b_q);
      ovf_q <= alu_ovf(op_q, a_q, b_q);
      id_q  <= gnt_q;
    end
  end

  assign bus.req_ready  = ready_d;
  assign bus.rsp_valid  = rsp_valid_d;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_ne     = ne_q;
  assign bus.rsp_lt     = lt_q;
  assign bus.rsp_ovf    = ovf_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle-level reference model plus directed literal checks.
module tb_alu_arbiter;
  localparam int N   = 2;
  localparam int IDW = 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   passes  = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_arbiter_if #(.NUM_REQ(N), .IDW(IDW)) bus ();
  alu_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference semantics written from the opcode table with wide arithmetic.
  function automatic logic [31:0] m_result(input logic [4:0] op, input logic [4:0] sh,
                                           input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return $signed(a) >>> sh;
      default: return a + b;
    endcase
  endfunction

  function automatic logic m_overflow(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = (op == 5'd1) ? sa - sb : sa + sb;
    if (op >= 5'd2 && op <= 5'd5) return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic int m_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  bit          live = 1'b0;
  int          age = 0, owner = 0, prio = 0, acc_cyc = 0, m_w = 0;
  logic [31:0] m_res;
  logic        m_ne, m_lt, m_ovf;
  logic [31:0] a_w, b_w;
  int          grant_log[$];
  logic [31:0] res_log[$];
  int          id_log[$];

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      live = 1'b0;
      prio = 0;
    end else if (!live) begin
      m_w = m_winner(bus.req_valid, prio);
      chk("idle_busy", bus.busy, 0);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
      chk("idle_req_ready", bus.req_ready, (m_w >= 0) ? (32'd1 << m_w) : 32'd0);
      if (m_w >= 0) begin
        a_w   = bus.req_a[32*m_w +: 32];
        b_w   = bus.req_b[32*m_w +: 32];
        m_res = m_result(bus.req_opcode[5*m_w +: 5], bus.req_shamt[5*m_w +: 5], a_w, b_w);
        m_ovf = m_overflow(bus.req_opcode[5*m_w +: 5], a_w, b_w);
        m_ne  = (a_w != b_w);
        m_lt  = ($signed(a_w) < $signed(b_w));
        live    = 1'b1;
        age     = 1;
        owner   = m_w;
        acc_cyc = cyc;
        grant_log.push_back(m_w);
`ifndef ALU_ARB_FIXED_PRIO_EN
        prio = (m_w + 1) % N;
`endif
      end
    end else begin
      chk("busy_busy", bus.busy, 1);
      chk("busy_req_ready", bus.req_ready, 0);
      if (age < 2) begin
        chk("exec_rsp_valid", bus.rsp_valid, 0);
      end else begin
        chk("rsp_valid", bus.rsp_valid, 32'd1 << owner);
        chk("rsp_id", bus.rsp_id, owner);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_ne", bus.rsp_ne, m_ne);
        chk("rsp_lt", bus.rsp_lt, m_lt);
        chk("rsp_ovf", bus.rsp_ovf, m_ovf);
        if (bus.rsp_ready[owner]) begin
          res_log.push_back(bus.rsp_result);
          id_log.push_back(int'(bus.rsp_id));
          live = 1'b0;
        end
      end
      age++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]          = 1'b1;
    bus.req_opcode[5*i +: 5]  = op;
    bus.req_shamt[5*i +: 5]   = sh;
    bus.req_a[32*i +: 32]     = a;
    bus.req_b[32*i +: 32]     = b;
  endtask

  task automatic wait_ready(input int i, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clock);
      if (bus.req_ready[i]) ok = 1'b1;
    end
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: req_ready[%0d] not seen within 20 cycles", name, i);
  endtask

  task automatic wait_rsp(input int i, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clock);
      if (bus.rsp_valid[i]) ok = 1'b1;
    end
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: rsp_valid[%0d] not seen within 20 cycles", name, i);
  endtask

  task automatic wait_log(input int n, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clock);
      if (res_log.size() >= n) ok = 1'b1;
    end
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %0d responses seen, expected %0d", name, res_log.size(), n);
  endtask

  task automatic run1(input int i, input logic [4:0] op, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                      input logic ene, input logic elt, input logic eovf, input string name);
    set_req(i, op, sh, a, b);
    wait_ready(i, {name, "_acc"});
    step();
    bus.req_valid[i] = 1'b0;
    wait_rsp(i, {name, "_rsp"});
    chk({name, "_lat"}, cyc - acc_cyc, 2);
    chk({name, "_res"}, bus.rsp_result, er);
    chk({name, "_id"}, bus.rsp_id, i);
    chk({name, "_ne"}, bus.rsp_ne, ene);
    chk({name, "_lt"}, bus.rsp_lt, elt);
    chk({name, "_ovf"}, bus.rsp_ovf, eovf);
    step();
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  int          exp_g[4] = '{0, 0, 0, 0};
  logic [31:0] exp_r1   = 32'd7;
`else
  int          exp_g[4] = '{0, 1, 0, 1};
  logic [31:0] exp_r1   = 32'hFF;
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_shamt  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = '1;

    @(negedge clock);
    chk("por_result", bus.rsp_result, 0);
    chk("por_id", bus.rsp_id, 0);
    chk("por_flags", {bus.rsp_ne, bus.rsp_lt, bus.rsp_ovf}, 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    run1(0, 5'd0, 5'd0, 32'd5, 32'd7, 32'd12, 1'b1, 1'b1, 1'b0, "t1_add");

    // Two requesters held valid from reset
    do_reset();
    grant_log.delete();
    res_log.delete();
    id_log.delete();
    set_req(0, 5'd1, 5'd0, 32'd10, 32'd3);
    set_req(1, 5'd3, 5'd0, 32'hF0, 32'h0F);
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        @(negedge clock);
        if (grant_log.size() >= 4) ok = 1'b1;
      end
      chk("rr_four_accepts", ok, 1);
    end
    step();
    bus.req_valid = '0;
    wait_log(4, "rr_four_rsps");
    step();
    for (int k = 0; k < 4; k++) chk($sformatf("grant_order_%0d", k), grant_log[k], exp_g[k]);
    chk("rr_first_result", res_log[0], 32'd7);
    chk("rr_first_id", id_log[0], 0);
    chk("rr_second_result", res_log[1], exp_r1);
    chk("rr_second_id", id_log[1], exp_g[1]);

    // Backpressure on requester 0 while requester 1 waits
    bus.rsp_ready = '0;
    set_req(0, 5'd0, 5'd0, 32'h100, 32'h23);
    set_req(1, 5'd4, 5'd3, 32'd1, 32'd0);
    wait_ready(0, "bp_acc");
    step();
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, "bp_rsp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_hold_valid", bus.rsp_valid, 2'b01);
      chk("bp_hold_result", bus.rsp_result, 32'h123);
      chk("bp_hold_ready", bus.req_ready, 0);
    end
    step();
    bus.rsp_ready = 2'b01;
    @(negedge clock);
    chk("bp_still_resp", bus.rsp_valid, 2'b01);
    step();
    @(negedge clock);
    chk("bp_idle_busy", bus.busy, 0);
    chk("bp_next_grant", bus.req_ready, 2'b10);
    step();
    bus.req_valid[1] = 1'b0;
    wait_rsp(1, "bp_r1_rsp");
    chk("bp_r1_result", bus.rsp_result, 32'd8);
    @(negedge clock);
    chk("non_owner_ready_ignored", bus.rsp_valid, 2'b10);
    step();
    bus.rsp_ready = '1;
    step();
    step();

    // Overflow masking and operand-width corners
    run1(0, 5'd2, 5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, "and_mask");
    run1(0, 5'd5, 5'd4, 32'h80000000, 32'd0, 32'hF8000000, 1'b1, 1'b1, 1'b0, "sra");
    run1(1, 5'd0, 5'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1'b1, "add_ovf");
    run1(0, 5'd1, 5'd0, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, "sub_ovf");
    run1(1, 5'd9, 5'd0, 32'd3, 32'd4, 32'd7, 1'b1, 1'b1, 1'b0, "op9_add");
    run1(0, 5'd3, 5'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, "or_mask");
    run1(1, 5'd4, 5'd31, 32'd1, 32'd5, 32'h80000000, 1'b1, 1'b1, 1'b0, "sll31");

    // Reset while a response is held
    bus.rsp_ready = '0;
    set_req(0, 5'd0, 5'd0, 32'd1, 32'd2);
    wait_ready(0, "rst_acc");
    step();
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, "rst_rsp");
    step();
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rsp_id", bus.rsp_id, 0);
    chk("midrst_result", bus.rsp_result, 0);
    chk("midrst_flags", {bus.rsp_ne, bus.rsp_lt, bus.rsp_ovf}, 0);
    chk("midrst_busy", bus.busy, 0);
    step();
    reset_n = 1'b1;
    bus.rsp_ready = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("postrst_no_rsp", bus.rsp_valid, 0);
    end
    step();
    set_req(0, 5'd0, 5'd0, 32'd2, 32'd2);
    set_req(1, 5'd0, 5'd0, 32'd9, 32'd9);
    @(negedge clock);
    chk("postrst_first_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = '0;
    wait_rsp(0, "postrst_rsp");
    chk("postrst_result", bus.rsp_result, 32'd4);
    step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
